// File: rtl/pipe_exc_ctrl.sv
// Exception/eret sequencer: prioritises WB-stage exceptions and interrupts, flushes the pipe,
// then redirects the PC. Build macro PIPE_EXC_INT_EN enables external-interrupt sampling.
module pipe_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_F000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        WB_Overflow,
  input  logic        WB_Divide_zero,
  input  logic        WB_Syscall,
  input  logic        WB_Break,
  input  logic        WB_Reserved_instruction,
  input  logic        WB_Eret,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_opcplus4,
  input  logic [5:0]  ext_int,
  input  logic        int_enable,
  input  logic [31:0] epc_in,
  output logic        wb_kill,
  output logic        flush_all,
  output logic        stall_pc,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        cp0_epc_we,
  output logic [31:0] epc_out,
  output logic [4:0]  cause_code,
  output logic        exl,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       is_exc;
  logic       int_req;
  logic       sync_exc;
  logic [4:0] sync_code;

`ifdef PIPE_EXC_INT_EN
  // Interrupts are masked while already at exception level.
  assign int_req = int_enable & (|ext_int) & ~exl;
`else
  logic unused_int_inputs;
  assign int_req           = 1'b0;
  assign unused_int_inputs = ^{ext_int, int_enable, WB_opcplus4};
`endif

  assign sync_exc = WB_Overflow | WB_Divide_zero | WB_Syscall | WB_Break | WB_Reserved_instruction;

  always_comb begin
    sync_code = 5'd0;
    if (WB_Reserved_instruction) sync_code = 5'd10;
    else if (WB_Overflow)        sync_code = 5'd12;
    else if (WB_Divide_zero)     sync_code = 5'd13;
    else if (WB_Syscall)         sync_code = 5'd8;
    else if (WB_Break)           sync_code = 5'd9;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= 3'd0;
      is_exc          <= 1'b0;
      exl             <= 1'b0;
      redirect_target <= 32'd0;
      epc_out         <= 32'd0;
      cause_code      <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= 3'd0;
          if (int_req) begin
            cause_code      <= 5'd0;
            epc_out         <= WB_opcplus4;
            redirect_target <= EXC_VECTOR;
            is_exc          <= 1'b1;
            state           <= S_FLUSH;
          end else if (sync_exc) begin
            cause_code      <= sync_code;
            epc_out         <= WB_PC;
            redirect_target <= EXC_VECTOR;
            is_exc          <= 1'b1;
            state           <= S_FLUSH;
          end else if (WB_Eret) begin
            // Eret carries no cause; cause_code/epc_out keep their last values.
            redirect_target <= epc_in;
            is_exc          <= 1'b0;
            state           <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          cnt <= cnt + 3'd1;
          if (cnt == FLUSH_LAST) state <= S_REDIRECT;
        end
        S_REDIRECT: begin
          exl   <= is_exc;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // exl only changes on leaving REDIRECT, so here it still holds its value at sequence entry.
  assign cp0_epc_we  = (state == S_REDIRECT) & is_exc & ~exl;
  assign wb_kill     = (state == S_IDLE) & sync_exc;
  assign flush_all   = (state == S_FLUSH) | (state == S_REDIRECT);
  assign stall_pc    = (state == S_FLUSH);
  assign pc_redirect = (state == S_REDIRECT);
  assign busy        = (state != S_IDLE);
  assign fsm_state   = state;

endmodule
